// File: rtl/synch_ram_pkg.sv
// Shared types and constants for the synchronous single-port RAM.
package synch_ram_pkg;

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_e;

  localparam int unsigned RD_LAT_MIN = 1;
  localparam int unsigned RD_LAT_MAX = 2;

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat >= RD_LAT_MIN) && (lat <= RD_LAT_MAX);
  endfunction

endpackage

// File: rtl/sp_ram_array.sv
// Storage array: byte-enable write and registered read, no reset so it maps to block RAM.
module sp_ram_array #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < int'(BE_W); i++) begin
        if (i_be[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
    o_rdata <= r_mem[i_addr];
  end

endmodule

// File: rtl/synch_sp_ram_param.sv
// Single-port RAM top: clear sequencer FSM, req/ready handshake, range check and read/err pipe.
module synch_sp_ram_param
  import synch_ram_pkg::*;
#(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned ADDR_W = 4,
  parameter int unsigned DEPTH  = 1 << ADDR_W,
  parameter int unsigned RD_LAT = 1,
  parameter int unsigned BE_W   = DATA_W / 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic [BE_W-1:0]   be,
  output logic              ready,
  output logic [DATA_W-1:0] rdata,
  output logic              rvalid,
  output logic              err,
  output logic              init_done
);

  localparam int unsigned CMP_W        = ADDR_W + 1;
  localparam bit          RD_LAT_LEGAL = rd_lat_ok(RD_LAT);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [ADDR_W-1:0] r_clr_ptr;
  logic              r_init_done;
  logic              w_clr_last;
  logic              w_acc;
  logic              w_in_range;

  logic              w_mem_we;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;
  logic [BE_W-1:0]   w_mem_be;
  logic [DATA_W-1:0] w_arr_rdata;

  logic              r_rv1;
  logic              r_oor1;
  logic              r_werr1;
  logic              w_fv;
  logic              w_foor;
  logic [DATA_W-1:0] w_fdata;

  assign w_clr_last = (r_clr_ptr == ADDR_W'(DEPTH - 1));
  assign ready      = (r_state == IDLE);
  assign init_done  = r_init_done;
  assign w_acc      = req & ready;
  assign w_in_range = (CMP_W'(addr) < CMP_W'(DEPTH));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= CLEAR;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if ((r_state == CLEAR) && w_clr_last) w_state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_clr_ptr   <= '0;
      r_init_done <= 1'b0;
    end else if (r_state == CLEAR) begin
      r_clr_ptr <= r_clr_ptr + ADDR_W'(1);
      if (w_clr_last) r_init_done <= 1'b1;
    end
  end

  // Clear sequencer owns the write port during CLEAR; out-of-range user writes are dropped.
  always_comb begin
    w_mem_we    = w_acc & we & w_in_range;
    w_mem_addr  = addr;
    w_mem_wdata = wdata;
    w_mem_be    = be;
    if (r_state == CLEAR) begin
      w_mem_we    = 1'b1;
      w_mem_addr  = r_clr_ptr;
      w_mem_wdata = '0;
      w_mem_be    = '1;
    end
  end

  sp_ram_array #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .BE_W   (BE_W)
  ) u_array (
    .clk     (clk),
    .i_we    (w_mem_we),
    .i_addr  (w_mem_addr),
    .i_wdata (w_mem_wdata),
    .i_be    (w_mem_be),
    .o_rdata (w_arr_rdata)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_rv1   <= 1'b0;
      r_oor1  <= 1'b0;
      r_werr1 <= 1'b0;
    end else begin
      r_rv1   <= w_acc & ~we;
      r_oor1  <= w_acc & ~we & ~w_in_range;
      r_werr1 <= w_acc & we & ~w_in_range;
    end
  end

  // Optional non-stallable stage between the array register and the output register.
  generate
    if (RD_LAT_LEGAL && (RD_LAT == 2)) begin : g_lat2
      logic              r_rv2;
      logic              r_oor2;
      logic [DATA_W-1:0] r_d2;
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          r_rv2  <= 1'b0;
          r_oor2 <= 1'b0;
          r_d2   <= '0;
        end else begin
          r_rv2  <= r_rv1;
          r_oor2 <= r_oor1;
          r_d2   <= w_arr_rdata;
        end
      end
      assign w_fv    = r_rv2;
      assign w_foor  = r_oor2;
      assign w_fdata = r_d2;
    end else begin : g_lat1
      assign w_fv    = r_rv1;
      assign w_foor  = r_oor1;
      assign w_fdata = w_arr_rdata;
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rvalid <= 1'b0;
      rdata  <= '0;
      err    <= 1'b0;
    end else begin
      rvalid <= w_fv;
      err    <= (w_fv & w_foor) | r_werr1;
      if (w_fv) rdata <= w_foor ? '0 : w_fdata;
    end
  end

endmodule
